// File: rtl/game_pkg.sv
// Shared types and sizes for the collision event scheduler.
//   NUM_COLL / ID_W / CNT_W : default collision-vector, event-id and counter widths
//   coll_e                  : symbolic names for each collision bit index
//   state_e                 : issue FSM states
package game_pkg;
  localparam int NUM_COLL = 10;
  localparam int ID_W     = $clog2(NUM_COLL);
  localparam int CNT_W    = 8;

  typedef enum logic [ID_W-1:0] {
    COLL_PLAYER_MMISSILE  = 4'd0,
    COLL_PLAYER_MONSTER   = 4'd1,
    COLL_MONSTER_PMISSILE = 4'd2,
    COLL_MONSTER_SHIELD   = 4'd3,
    COLL_SHIELD_PMISSILE  = 4'd4,
    COLL_SHIELD_MMISSILE  = 4'd5,
    COLL_BORDER_PLAYER    = 4'd6,
    COLL_BORDER_MONSTER   = 4'd7,
    COLL_BORDER_PMISSILE  = 4'd8,
    COLL_BORDER_MMISSILE  = 4'd9
  } coll_e;

  typedef enum logic {ST_IDLE, ST_PRESENT} state_e;
endpackage

// File: rtl/lsb_priority_encoder.sv
// Combinational lowest-set-bit encoder.
//   vec_i : input vector
//   idx_o : index of the lowest set bit (0 when none set)
//   any_o : high when any bit of vec_i is set
module lsb_priority_encoder #(
  parameter int N = 10,
  parameter int W = 4
) (
  input  logic [N-1:0] vec_i,
  output logic [W-1:0] idx_o,
  output logic         any_o
);
  // Scan downwards so the lowest set index is written last and wins.
  always_comb begin
    idx_o = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec_i[i]) idx_o = W'(i);
    end
  end

  assign any_o = |vec_i;
endmodule

// File: rtl/collision_event_scheduler.sv
// Collects per-pixel collision flags over a frame, snapshots them at frame
// start and issues each snapshotted bit as one event over valid/ready,
// lowest index first.
//   clk, resetN   : clock, asynchronous active-low reset
//   startOfFrame  : one-cycle frame-start pulse
//   collision     : raw collision flags, sampled every cycle
//   evt_ready     : consumer accepts the presented event
//   evt_valid/id  : presented event and its collision index
//   frame_hits    : last frame's accumulated collisions
//   overrun       : pulse when a frame starts with events still pending
//   overrun_cnt   : saturating count of overrun pulses
module collision_event_scheduler #(
  parameter int                           NUM_COLL    = game_pkg::NUM_COLL,
  parameter logic [game_pkg::NUM_COLL-1:0] ENABLE_MASK = 10'h3FF,
  parameter int                           CNT_W       = game_pkg::CNT_W,
  parameter int                           ID_W        = game_pkg::ID_W
) (
  input  logic                clk,
  input  logic                resetN,
  input  logic                startOfFrame,
  input  logic [NUM_COLL-1:0] collision,
  input  logic                evt_ready,
  output logic                evt_valid,
  output logic [ID_W-1:0]     evt_id,
  output logic [NUM_COLL-1:0] frame_hits,
  output logic                overrun,
  output logic [CNT_W-1:0]    overrun_cnt
);
  import game_pkg::*;

  logic [NUM_COLL-1:0] acc_q, acc_d, pend_q, pend_d, hits_q, hits_d;
  logic [NUM_COLL-1:0] snap, clr, pend_kept;
  logic [ID_W-1:0]     id_q, id_d, enc_idx;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                ovr_q, ovr_d, enc_any, hs;
  state_e              state_q, state_d;

  lsb_priority_encoder #(.N(NUM_COLL), .W(ID_W)) u_enc (
    .vec_i (pend_q),
    .idx_o (enc_idx),
    .any_o (enc_any)
  );

  // Same-cycle hits are folded into the snapshot so nothing on the
  // frame-start cycle is dropped.
  assign snap      = acc_q | (collision & ENABLE_MASK);
  assign hs        = (state_q == ST_PRESENT) && evt_ready;
  assign clr       = hs ? (NUM_COLL'(1) << id_q) : '0;
  // Clear first, then merge: a bit retired this cycle and re-hit in the new
  // frame stays pending and is not counted as an overrun.
  assign pend_kept = pend_q & ~clr;
  assign pend_d    = pend_kept | (startOfFrame ? snap : '0);
  assign acc_d     = startOfFrame ? '0 : snap;
  assign hits_d    = startOfFrame ? snap : hits_q;
  assign ovr_d     = startOfFrame && (|pend_kept);
  assign cnt_d     = (ovr_d && (cnt_q != '1)) ? cnt_q + CNT_W'(1) : cnt_q;

  // Issue FSM: the id is latched on entry to PRESENT and held until accepted,
  // so a new snapshot never preempts the event on the bus.
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    case (state_q)
      ST_IDLE: begin
        if (enc_any) begin
          id_d    = enc_idx;
          state_d = ST_PRESENT;
        end
      end
      ST_PRESENT: begin
        if (evt_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      acc_q   <= '0;
      pend_q  <= '0;
      hits_q  <= '0;
      id_q    <= '0;
      cnt_q   <= '0;
      ovr_q   <= 1'b0;
      state_q <= ST_IDLE;
    end else begin
      acc_q   <= acc_d;
      pend_q  <= pend_d;
      hits_q  <= hits_d;
      id_q    <= id_d;
      cnt_q   <= cnt_d;
      ovr_q   <= ovr_d;
      state_q <= state_d;
    end
  end

  assign evt_valid   = (state_q == ST_PRESENT);
  assign evt_id      = id_q;
  assign frame_hits  = hits_q;
  assign overrun     = ovr_q;
  assign overrun_cnt = cnt_q;
endmodule

// File: tb/tb_collision_event_scheduler.sv
module tb_collision_event_scheduler;
  logic       clk = 1'b0;
  logic       resetN = 1'b0;
  logic       sof = 1'b0;
  logic [9:0] coll = '0;
  logic       rdy = 1'b0;

  logic       v1, ov1, v2, ov2;
  logic [3:0] id1, id2;
  logic [9:0] fh1, fh2;
  logic [7:0] cnt1, cnt2;

  int errors = 0;
  int checks = 0;
  int hs_log[$];

  // behavioural reference: event set, frame accumulation, one presented event
  logic [9:0] m_acc, m_pend, m_hits;
  logic       m_valid, m_ovr;
  int         m_id, m_cnt;

  always #5 clk = ~clk;

  collision_event_scheduler dut (
    .clk(clk), .resetN(resetN), .startOfFrame(sof), .collision(coll),
    .evt_ready(rdy), .evt_valid(v1), .evt_id(id1), .frame_hits(fh1),
    .overrun(ov1), .overrun_cnt(cnt1)
  );

  collision_event_scheduler #(.ENABLE_MASK(10'h3FE)) dut_m (
    .clk(clk), .resetN(resetN), .startOfFrame(sof), .collision(coll),
    .evt_ready(1'b1), .evt_valid(v2), .evt_id(id2), .frame_hits(fh2),
    .overrun(ov2), .overrun_cnt(cnt2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int lowest(input logic [9:0] v);
    for (int i = 0; i < 10; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic m_reset();
    m_acc = '0; m_pend = '0; m_hits = '0;
    m_valid = 1'b0; m_ovr = 1'b0; m_id = 0; m_cnt = 0;
  endtask

  // One clock of the reference, applied to the inputs held across the edge.
  task automatic m_step(input logic s, input logic [9:0] c, input logic r);
    logic [9:0] snap, remaining;
    logic       accepted;
    snap      = m_acc | c;
    accepted  = m_valid && r;
    remaining = m_pend;
    if (accepted) remaining[m_id] = 1'b0;
    m_ovr = s && (remaining != 0);
    if (m_ovr && m_cnt < 255) m_cnt++;
    if (s) begin
      m_hits = snap;
      m_acc  = '0;
      remaining = remaining | snap;
    end else begin
      m_acc = snap;
    end
    if (m_valid) begin
      if (accepted) m_valid = 1'b0;
    end else if (m_pend != 0) begin
      m_valid = 1'b1;
      m_id    = lowest(m_pend);
    end
    m_pend = remaining;
  endtask

  task automatic compare_all();
    chk("evt_valid", 32'(v1), 32'(m_valid));
    if (m_valid) chk("evt_id", 32'(id1), 32'(m_id));
    chk("frame_hits", 32'(fh1), 32'(m_hits));
    chk("overrun", 32'(ov1), 32'(m_ovr));
    chk("overrun_cnt", 32'(cnt1), 32'(m_cnt));
  endtask

  // Called with clk low; drives inputs, steps reference at the edge, checks at negedge.
  task automatic cycle(input logic s, input logic [9:0] c, input logic r);
    sof = s; coll = c; rdy = r;
    if (v1 && r) hs_log.push_back(int'(id1));
    @(posedge clk);
    m_step(s, c, r);
    @(negedge clk);
    compare_all();
  endtask

  task automatic do_reset();
    sof = 1'b0; coll = '0; rdy = 1'b0;
    #2 resetN = 1'b0;
    #1;
    chk("rst_valid", 32'(v1), 32'd0);
    chk("rst_id", 32'(id1), 32'd0);
    chk("rst_hits", 32'(fh1), 32'd0);
    chk("rst_ovr", 32'(ov1), 32'd0);
    chk("rst_cnt", 32'(cnt1), 32'd0);
    m_reset();
    @(negedge clk);
    resetN = 1'b1;
    hs_log.delete();
  endtask

  initial begin
    m_reset();
    @(negedge clk);
    do_reset();

    // masked source never accumulates
    for (int i = 0; i < 3; i++) cycle(1'b0, 10'h001, 1'b0);
    cycle(1'b1, 10'h001, 1'b0);
    chk("mask_hits", 32'(fh2), 32'd0);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 10'h000, 1'b0);
      chk("mask_valid", 32'(v2), 32'd0);
    end

    // single event, two-cycle latency
    do_reset();
    cycle(1'b0, 10'h004, 1'b1);
    cycle(1'b1, 10'h000, 1'b1);
    chk("t1_hits", 32'(fh1), 32'h004);
    chk("t1_v_T1", 32'(v1), 32'd0);
    cycle(1'b0, 10'h000, 1'b1);
    chk("t1_v_T2", 32'(v1), 32'd1);
    chk("t1_id", 32'(id1), 32'(game_pkg::COLL_MONSTER_PMISSILE));
    for (int i = 0; i < 4; i++) cycle(1'b0, 10'h000, 1'b1);
    chk("t1_count", 32'(hs_log.size()), 32'd1);

    // priority order, one bubble between events
    do_reset();
    cycle(1'b0, 10'h200, 1'b1);
    cycle(1'b0, 10'h008, 1'b1);
    cycle(1'b0, 10'h001, 1'b1);
    cycle(1'b1, 10'h000, 1'b1);
    for (int i = 0; i < 8; i++) cycle(1'b0, 10'h000, 1'b1);
    chk("t2_count", 32'(hs_log.size()), 32'd3);
    if (hs_log.size() == 3) begin
      chk("t2_id0", 32'(hs_log[0]), 32'd0);
      chk("t2_id1", 32'(hs_log[1]), 32'd3);
      chk("t2_id2", 32'(hs_log[2]), 32'd9);
    end
    chk("t2_cnt", 32'(cnt1), 32'd0);

    // overrun while stalled, no preemption
    do_reset();
    cycle(1'b0, 10'h020, 1'b0);
    cycle(1'b1, 10'h000, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 10'h000, 1'b0);
    cycle(1'b0, 10'h002, 1'b0);
    cycle(1'b1, 10'h000, 1'b0);
    chk("t3_ovr", 32'(ov1), 32'd1);
    chk("t3_cnt", 32'(cnt1), 32'd1);
    chk("t3_hold", 32'(id1), 32'd5);
    cycle(1'b0, 10'h000, 1'b0);
    chk("t3_pulse", 32'(ov1), 32'd0);
    for (int i = 0; i < 6; i++) cycle(1'b0, 10'h000, 1'b1);
    chk("t3_count", 32'(hs_log.size()), 32'd2);
    if (hs_log.size() == 2) begin
      chk("t3_first", 32'(hs_log[0]), 32'd5);
      chk("t3_second", 32'(hs_log[1]), 32'd1);
    end

    // handshake coincides with re-snapshot of the same bit
    do_reset();
    cycle(1'b0, 10'h008, 1'b0);
    cycle(1'b1, 10'h000, 1'b0);
    cycle(1'b0, 10'h000, 1'b0);
    cycle(1'b1, 10'h008, 1'b1);
    chk("t4_ovr", 32'(ov1), 32'd0);
    for (int i = 0; i < 6; i++) cycle(1'b0, 10'h000, 1'b1);
    chk("t4_count", 32'(hs_log.size()), 32'd2);
    chk("t4_cnt", 32'(cnt1), 32'd0);

    // async reset during PRESENT
    do_reset();
    cycle(1'b0, 10'h010, 1'b0);
    cycle(1'b1, 10'h000, 1'b0);
    cycle(1'b0, 10'h000, 1'b0);
    chk("t6_pre", 32'(v1), 32'd1);
    do_reset();
    cycle(1'b0, 10'h000, 1'b1);
    cycle(1'b1, 10'h000, 1'b1);
    for (int i = 0; i < 4; i++) cycle(1'b0, 10'h000, 1'b1);
    chk("t6_none", 32'(hs_log.size()), 32'd0);

    // overrun counter saturation
    do_reset();
    cycle(1'b0, 10'h001, 1'b0);
    for (int i = 0; i < 260; i++) begin
      cycle(1'b1, 10'h001, 1'b0);
      cycle(1'b0, 10'h000, 1'b0);
    end
    chk("sat_cnt", 32'(cnt1), 32'hFF);

    // randomized traffic against the reference
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      cycle(($urandom_range(7) == 0),
            10'($urandom) & 10'($urandom) & 10'($urandom),
            ($urandom_range(9) < 7));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
